read_burst_req_ctrl: RTL and testbench
======================================

Name: read_burst_req_ctrl

Overview:
- Frame-level AXI read-address issuer that sits directly downstream of the read line-length tracker.
- Once `fsync` starts a frame, it issues fixed-length bursts from a base address. When the tracker raises `tail_status`, it issues one final burst of `tail_len` beats.
- It reports each finished burst back to the tracker as a `burst_done` or `tail_done` level pulse; the tracker acts on the falling edge.
- R-channel data goes straight to the read FIFO; this block only counts beats and drives `rready`.

Parameters:
- NOR_BURST_LEN, 200, beats per normal burst (1..256).
- AXI_DSIZE, 256, AXI data width in bits; byte stride per beat = AXI_DSIZE/8.
- ASIZE, 32, address width.
- LSIZE, 9, width of `tail_len`.
- DONE_HOLD, 2, cycles each done pulse stays high (≥2 so the tracker's edge detector sees it).
- SETTLE_CYC, 4, wait cycles before sampling `tail_status`/`tail_len` (covers the tracker's registered update latency).

Ports:
- clock, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, allows new frames/bursts.
- fsync, input, 1, frame start pulse (same pulse drives the tracker).
- baseaddr, input, ASIZE, frame base byte address; sampled on `fsync`.
- tail_status, input, 1, next burst is the tail.
- tail_len, input, LSIZE, beats in the tail burst (1..NOR_BURST_LEN).
- fifo_afull, input, 1, downstream FIFO cannot accept a full burst.
- arvalid, output, 1, AXI AR valid.
- arready, input, 1, AXI AR ready.
- araddr, output, ASIZE, burst start address.
- arlen, output, 8, beats-1.
- rvalid, input, 1, AXI R valid.
- rlast, input, 1, AXI R last.
- rready, output, 1, AXI R ready.
- burst_done, output, 1, normal burst finished (level pulse).
- tail_done, output, 1, tail burst finished (level pulse).
- busy, output, 1, not in IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; address/beat counters 0; `restart` flag 0.
- States: IDLE, SETTLE, WAIT_ROOM, ADDR, DATA, DONE.
- IDLE:
  - `fsync` & `enable` → latch `cur_addr=baseaddr`; go to SETTLE.
  - `fsync` while `enable`=0 is ignored.
- SETTLE:
  - Counts SETTLE_CYC cycles, then goes to WAIT_ROOM.
  - `fsync` seen here re-latches `baseaddr` and restarts the count.
- WAIT_ROOM:
  - If `enable`=0 → IDLE.
  - Else if `fifo_afull`=0: sample `tail_status` into `is_tail`; `blen = is_tail ? tail_len : NOR_BURST_LEN`; load `arlen=blen-1` and `araddr=cur_addr`; go to ADDR.
- ADDR:
  - `arvalid`=1; `araddr`/`arlen` are held stable until `arready`.
  - On `arvalid`&`arready`: `arvalid`←0 next cycle; go to DATA.
- DATA:
  - `rready`=1.
  - Count beats on `rvalid`&`rready`.
  - On the beat with `rlast`, or beat count = `blen` (whichever first), go to DONE.
  - A count mismatch with `rlast` is not flagged; `rlast` wins.
- DONE:
  - If `restart`=0: drive `burst_done` (`is_tail`=0) or `tail_done` (`is_tail`=1) high for exactly DONE_HOLD cycles, then drop it.
  - Address update on entry: `cur_addr += blen*(AXI_DSIZE/8)` (ASIZE wrap allowed); on a tail, `cur_addr=baseaddr` instead.
  - Next state:
    - normal burst → SETTLE;
    - tail → IDLE, waiting for the next `fsync`;
    - `restart` set → SETTLE with `cur_addr=latched base` and `restart` cleared, no pulse.
- `fsync` during WAIT_ROOM / ADDR / DATA / DONE:
  - Set `restart` and latch `baseaddr`.
  - An accepted or pending AR is never withdrawn; the in-flight burst drains fully.
  - Its done pulse is suppressed, so the tracker's reload is not disturbed.
  - In WAIT_ROOM, `restart` jumps straight to SETTLE.
- `enable` low mid-burst: the current burst completes normally, including its pulse; the FSM then goes to IDLE at WAIT_ROOM.
- Arithmetic: `blen` is LSIZE+1 bits; the address increment is computed at full ASIZE width.
- `tail_len`=0 is treated as NOR_BURST_LEN.
- `busy`=1 in every state except IDLE.
- At most one outstanding AR at any time.

Test Plan:
- Normal burst, default params: `baseaddr`=0x1000_0000, `fsync`, `tail_status`=0 → AR 4+ cycles after `fsync` with `araddr`=0x1000_0000, `arlen`=199; after 200 beats, `burst_done` high 2 cycles; next AR `araddr`=0x1000_1900.
- Tail burst: after 3 normal bursts, bench raises `tail_status`, `tail_len`=37 → AR `araddr`=0x1000_4B00, `arlen`=36; after `rlast`, `tail_done` high 2 cycles, `burst_done` stays 0; then IDLE with `busy`=0 and no further AR until the next `fsync`.
- AR backpressure: hold `arready`=0 for 10 cycles → `arvalid`, `araddr`, `arlen` stable throughout; exactly one handshake.
- FIFO throttle: `fifo_afull`=1 in WAIT_ROOM for 20 cycles → no `arvalid`; AR issues 1 cycle after `fifo_afull` falls.
- Mid-burst `fsync`: `fsync` with `baseaddr`=0x2000_0000 at beat 50 → all 200 beats accepted, no done pulse; next AR `araddr`=0x2000_0000, `arlen`=199.
- Reset mid-DATA: assert `rst` for 1 cycle → next cycle all outputs 0, state IDLE; no AR until a new `fsync`.

Source files
------------

// File: rtl/read_burst_req_ctrl.sv
// rtl/read_burst_req_ctrl.sv - frame-level AXI read-address issuer with burst/tail done reporting
//
// Purpose:
//   After fsync starts a frame, issues fixed NOR_BURST_LEN-beat AXI read bursts from a base
//   address. When the line-length tracker raises tail_status, issues one final tail_len-beat
//   burst and returns to IDLE. Each finished burst is reported as a DONE_HOLD-cycle level pulse
//   on burst_done or tail_done. R data bypasses this block; it only counts beats and drives rready.
//
// Ports:
//   clock, rst            single clock, synchronous active-high reset
//   enable                allows new frames and bursts
//   fsync, baseaddr       frame start pulse and frame base byte address
//   tail_status, tail_len next burst is the tail, and its beat count (0 means NOR_BURST_LEN)
//   fifo_afull            downstream FIFO cannot take a full burst
//   arvalid/arready/araddr/arlen   AXI AR channel (one outstanding AR at most)
//   rvalid/rlast/rready   AXI R channel handshake (data goes elsewhere)
//   burst_done, tail_done finished-burst level pulses to the tracker
//   busy                  high in every state except IDLE
module read_burst_req_ctrl #(
    parameter int NOR_BURST_LEN = 200,
    parameter int AXI_DSIZE     = 256,
    parameter int ASIZE         = 32,
    parameter int LSIZE         = 9,
    parameter int DONE_HOLD     = 2,
    parameter int SETTLE_CYC    = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic             fsync,
    input  logic [ASIZE-1:0] baseaddr,
    input  logic             tail_status,
    input  logic [LSIZE-1:0] tail_len,
    input  logic             fifo_afull,
    output logic             arvalid,
    input  logic             arready,
    output logic [ASIZE-1:0] araddr,
    output logic [7:0]       arlen,
    input  logic             rvalid,
    input  logic             rlast,
    output logic             rready,
    output logic             burst_done,
    output logic             tail_done,
    output logic             busy
);

    localparam int BLW = LSIZE + 1;
    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam int DCW = $clog2(DONE_HOLD + 1);
    localparam logic [BLW-1:0]   NOR_BLEN = BLW'(NOR_BURST_LEN);
    localparam logic [ASIZE-1:0] STRIDE   = ASIZE'(AXI_DSIZE / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_ROOM,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SCW-1:0]   settle_cnt;
    logic [DCW-1:0]   done_cnt;
    logic [BLW-1:0]   beat_cnt;
    logic [BLW-1:0]   blen;
    logic [BLW-1:0]   blen_sel;
    logic [ASIZE-1:0] cur_addr;
    logic [ASIZE-1:0] base_lat;
    logic [ASIZE-1:0] addr_incr;
    logic             restart;
    logic             is_tail;
    logic             beat_last;
    logic             settle_last;
    logic             done_last;
    logic             in_flight;

    // Length the next burst would have if launched now; tail_len of 0 means a full burst.
    always_comb begin
        blen_sel = NOR_BLEN;
        if (tail_status && (tail_len != '0)) begin
            blen_sel = BLW'(tail_len);
        end
    end

    assign addr_incr   = ASIZE'(blen) * STRIDE;
    assign beat_last   = (beat_cnt == blen - BLW'(1));
    assign settle_last = (settle_cnt == SCW'(SETTLE_CYC - 1));
    assign done_last   = (done_cnt == DCW'(DONE_HOLD - 1));
    // States in which an fsync cannot abort anything and is deferred through restart.
    assign in_flight   = (state == S_ADDR) || (state == S_DATA) || (state == S_DONE);

    assign arvalid = (state == S_ADDR);
    assign rready  = (state == S_DATA);
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fsync && enable) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!fsync && settle_last) begin
                    state_nxt = S_WAIT_ROOM;
                end
            end
            S_WAIT_ROOM: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (fsync) begin
                    state_nxt = S_SETTLE;
                end else if (!fifo_afull) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                // rlast wins over the beat count; a mismatch is silently accepted.
                if (rvalid && (rlast || beat_last)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (done_last) begin
                    if (restart || fsync) begin
                        state_nxt = S_SETTLE;
                    end else if (is_tail) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_SETTLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            done_cnt   <= '0;
            beat_cnt   <= '0;
            blen       <= '0;
            cur_addr   <= '0;
            base_lat   <= '0;
            restart    <= 1'b0;
            is_tail    <= 1'b0;
            araddr     <= '0;
            arlen      <= '0;
            burst_done <= 1'b0;
            tail_done  <= 1'b0;
        end else begin
            state <= state_nxt;

            // A new frame arriving mid-burst is remembered; the burst drains first.
            if (fsync && in_flight) begin
                restart  <= 1'b1;
                base_lat <= baseaddr;
            end

            case (state)
                S_IDLE: begin
                    if (fsync && enable) begin
                        cur_addr   <= baseaddr;
                        base_lat   <= baseaddr;
                        settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (fsync) begin
                        cur_addr   <= baseaddr;
                        base_lat   <= baseaddr;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SCW'(1);
                    end
                end
                S_WAIT_ROOM: begin
                    if (enable && fsync) begin
                        cur_addr   <= baseaddr;
                        base_lat   <= baseaddr;
                        settle_cnt <= '0;
                    end else if (enable && !fifo_afull) begin
                        is_tail <= tail_status;
                        blen    <= blen_sel;
                        araddr  <= cur_addr;
                        arlen   <= 8'(blen_sel - BLW'(1));
                    end
                end
                S_ADDR: begin
                    beat_cnt <= '0;
                end
                S_DATA: begin
                    if (rvalid) begin
                        beat_cnt <= beat_cnt + BLW'(1);
                        if (rlast || beat_last) begin
                            done_cnt <= '0;
                            if (is_tail) begin
                                cur_addr <= base_lat;
                            end else begin
                                cur_addr <= cur_addr + addr_incr;
                            end
                            // No pulse for a burst superseded by a new frame.
                            if (!(restart || fsync)) begin
                                burst_done <= !is_tail;
                                tail_done  <= is_tail;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // A pulse already started runs its full width so the tracker never sees a runt.
                    if (done_last) begin
                        burst_done <= 1'b0;
                        tail_done  <= 1'b0;
                        settle_cnt <= '0;
                        if (restart || fsync) begin
                            cur_addr <= fsync ? baseaddr : base_lat;
                            restart  <= 1'b0;
                        end
                    end else begin
                        done_cnt <= done_cnt + DCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_read_burst_req_ctrl.sv
// tb/tb_read_burst_req_ctrl.sv - self-checking bench for read_burst_req_ctrl
module tb_read_burst_req_ctrl;

    localparam int NOR_BURST_LEN = 200;
    localparam int STRIDE_B      = 32;
    localparam int DONE_HOLD     = 2;

    logic        clock;
    logic        rst;
    logic        enable;
    logic        fsync;
    logic [31:0] baseaddr;
    logic        tail_status;
    logic [8:0]  tail_len;
    logic        fifo_afull;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic        burst_done;
    logic        tail_done;
    logic        busy;

    read_burst_req_ctrl dut (
        .clock      (clock),
        .rst        (rst),
        .enable     (enable),
        .fsync      (fsync),
        .baseaddr   (baseaddr),
        .tail_status(tail_status),
        .tail_len   (tail_len),
        .fifo_afull (fifo_afull),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .arlen      (arlen),
        .rvalid     (rvalid),
        .rlast      (rlast),
        .rready     (rready),
        .burst_done (burst_done),
        .tail_done  (tail_done),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t ar_exp[$];
    int  done_exp[$];     // 1 = burst_done, 2 = tail_done

    int total = 0;
    int bad   = 0;
    int n_ar  = 0;
    int n_done = 0;
    int beats_left = 0;
    int beats_cur  = 0;
    int last_burst_beats = 0;
    int run_b = 0;
    int run_t = 0;
    logic        hold_chk = 1'b0;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Address of the k-th normal burst of a frame starting at base.
    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
        return base + 32'(k * NOR_BURST_LEN * STRIDE_B);
    endfunction

    function automatic int count_of(input int which);
        case (which)
            0:       return n_done;
            1:       return n_ar;
            default: return beats_cur;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_for(input string name, input int which, input int target, input int budget);
        int i;
        i = 0;
        while (i < budget && count_of(which) < target) begin
            step(1);
            i++;
        end
        chk(name, count_of(which) >= target, 1);
    endtask

    task automatic pulse_fsync(input logic [31:0] a);
        baseaddr = a;
        fsync    = 1'b1;
        step(1);
        fsync    = 1'b0;
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        ar_exp.push_back(e);
    endtask

    task automatic end_pulse(input int kind, input int run);
        chk("done_width", run, DONE_HOLD);
        chk("done_expected", done_exp.size() != 0, 1);
        if (done_exp.size() != 0) begin
            chk("done_kind", kind, done_exp.pop_front());
        end
        n_done++;
    endtask

    // AXI slave: returns arlen+1 beats back-to-back with rlast on the final beat.
    initial begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            rvalid = (beats_left > 0);
            rlast  = (beats_left == 1);
        end
    end

    // Compare process: every cycle, checks the DUT against the expected AR and pulse streams.
    initial begin
        ar_t e;
        forever begin
            @(negedge clock);
            if (rst) begin
                beats_left = 0;
                hold_chk   = 1'b0;
                run_b      = 0;
                run_t      = 0;
            end else begin
                chk("rready_vs_burst", rready, beats_left > 0);
                if (hold_chk) begin
                    chk("ar_hold_valid", arvalid, 1);
                    chk("ar_hold_addr", araddr, hold_addr);
                    chk("ar_hold_len", arlen, hold_len);
                end
                hold_chk  = arvalid && !arready;
                hold_addr = araddr;
                hold_len  = arlen;
                if (arvalid && arready) begin
                    chk("ar_single_outstanding", beats_left, 0);
                    chk("ar_expected", ar_exp.size() != 0, 1);
                    if (ar_exp.size() != 0) begin
                        e = ar_exp.pop_front();
                        chk("araddr", araddr, e.addr);
                        chk("arlen", arlen, e.len);
                    end
                    beats_left = int'(arlen) + 1;
                    beats_cur  = 0;
                    n_ar++;
                end
                if (rvalid && rready) begin
                    beats_cur++;
                    beats_left--;
                    if (rlast) last_burst_beats = beats_cur;
                end
                chk("done_exclusive", burst_done && tail_done, 0);
                if (burst_done) run_b++;
                else if (run_b > 0) begin
                    end_pulse(1, run_b);
                    run_b = 0;
                end
                if (tail_done) run_t++;
                else if (run_t > 0) begin
                    end_pulse(2, run_t);
                    run_t = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int b;
        int i;
        rst = 1'b1; enable = 1'b0; fsync = 1'b0; baseaddr = '0;
        tail_status = 1'b0; tail_len = '0; fifo_afull = 1'b0; arready = 1'b1;
        step(3);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_tail_done", tail_done, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        rst = 1'b0;
        step(2);

        // fsync while disabled is ignored.
        pulse_fsync(32'h1234_0000);
        step(10);
        chk("fsync_disabled_busy", busy, 0);
        enable = 1'b1;

        // Model pins.
        chk("model_pin_second", exp_addr(32'h1000_0000, 1), 32'h1000_1900);
        chk("model_pin_tail", exp_addr(32'h1000_0000, 3), 32'h1000_4B00);

        // Frame A: three normal bursts then a 37-beat tail; AR backpressure on burst 2.
        for (int k = 0; k < 3; k++) begin
            push_ar(exp_addr(32'h1000_0000, k), 8'(NOR_BURST_LEN - 1));
            done_exp.push_back(1);
        end
        push_ar(exp_addr(32'h1000_0000, 3), 8'd36);
        done_exp.push_back(2);

        baseaddr = 32'h1000_0000;
        fsync = 1'b1;
        lat = 0;
        @(negedge clock);
        if (!arvalid) lat++;
        @(posedge clock);
        #1;
        fsync = 1'b0;
        while (lat < 40) begin
            @(negedge clock);
            if (arvalid) break;
            lat++;
        end
        chk("ar_latency", lat, 6);
        step(1);

        wait_for("wait_done_a1", 0, 1, 400);
        arready = 1'b0;
        i = 0;
        while (i < 40 && !arvalid) begin
            step(1);
            i++;
        end
        chk("bp_arvalid_seen", arvalid, 1);
        b = n_ar;
        step(10);
        chk("bp_arvalid_still", arvalid, 1);
        chk("bp_no_handshake", n_ar, b);
        arready = 1'b1;
        wait_for("wait_done_a2", 0, 2, 400);
        wait_for("wait_done_a3", 0, 3, 400);
        tail_status = 1'b1;
        tail_len    = 9'd37;
        wait_for("wait_done_tail", 0, 4, 200);
        tail_status = 1'b0;
        chk("tail_beats", last_burst_beats, 37);
        step(3);
        chk("tail_idle_busy", busy, 0);
        step(30);
        chk("tail_no_more_ar", n_ar, 4);
        chk("tail_idle_busy_late", busy, 0);

        // Frame B: FIFO throttle before burst 2, then enable drops mid-burst.
        push_ar(exp_addr(32'h3000_0000, 0), 8'(NOR_BURST_LEN - 1));
        push_ar(exp_addr(32'h3000_0000, 1), 8'(NOR_BURST_LEN - 1));
        done_exp.push_back(1);
        done_exp.push_back(1);
        b = n_done;
        pulse_fsync(32'h3000_0000);
        wait_for("wait_done_b1", 0, b + 1, 400);
        fifo_afull = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("afull_no_arvalid", arvalid, 0);
        end
        fifo_afull = 1'b0;
        @(negedge clock);
        chk("afull_release_same_cycle", arvalid, 0);
        step(1);
        chk("afull_release_next_cycle", arvalid, 1);
        wait_for("wait_ar_b2", 1, 6, 20);
        enable = 1'b0;
        wait_for("wait_done_b2", 0, b + 2, 400);
        step(10);
        chk("enable_low_idle", busy, 0);
        chk("enable_low_no_ar", n_ar, 6);

        // Frame C: fsync at beat 50 restarts at the new base without a pulse.
        enable = 1'b1;
        push_ar(32'h4000_0000, 8'(NOR_BURST_LEN - 1));
        b = n_done;
        pulse_fsync(32'h4000_0000);
        wait_for("wait_ar_c1", 1, 7, 30);
        wait_for("wait_beat_50", 2, 50, 100);
        push_ar(32'h2000_0000, 8'(NOR_BURST_LEN - 1));
        done_exp.push_back(1);
        pulse_fsync(32'h2000_0000);
        wait_for("wait_ar_c2", 1, 8, 400);
        chk("restart_beats_drained", last_burst_beats, NOR_BURST_LEN);
        chk("restart_no_pulse", n_done, b);
        wait_for("wait_done_c2", 0, b + 1, 400);
        enable = 1'b0;
        step(10);
        chk("frame_c_idle", busy, 0);

        // Frame D: reset in the middle of the data phase.
        enable = 1'b1;
        push_ar(32'h5000_0000, 8'(NOR_BURST_LEN - 1));
        pulse_fsync(32'h5000_0000);
        wait_for("wait_ar_d1", 1, 9, 30);
        wait_for("wait_beat_20", 2, 20, 100);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_araddr", araddr, 0);
        chk("mid_rst_arlen", arlen, 0);
        chk("mid_rst_done", burst_done | tail_done, 0);
        step(30);
        chk("mid_rst_stays_idle", busy, 0);
        chk("mid_rst_no_ar", n_ar, 9);

        chk("ar_queue_drained", ar_exp.size(), 0);
        chk("done_queue_drained", done_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
